// File: rtl/timer_pkg.sv
// Shared types for the peripheral timer: count modes, tick-source selects and
// one-shot FSM states.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        CKS_DIV2 = 2'b00,
        CKS_DIV4 = 2'b01,
        CKS_DIV8 = 2'b10,
        CKS_EXT  = 2'b11
    } cks_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Encoding 11 is an alias of free-run.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_FREE : mode_e'(m);
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Tick source for the timer: 3-bit prescaler (pclk/2, /4, /8) or a
// synchronised rising edge of the asynchronous clk_in.
module timer_tick_gen
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       en,
    input  logic       load,
    input  logic [1:0] cks,
    input  logic       clk_in,
    output logic       tick
);

    logic [2:0]             pre;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ext_prev;
    logic                   run;
    logic                   hit;
    cks_e                   sel;

    assign run = en & ~load;
    assign sel = cks_e'(cks);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or posedge preset_n) begin
        if (preset_n) begin
            pre      <= 3'd0;
            sync     <= '0;
            ext_prev <= 1'b0;
        end else begin
            pre      <= run ? pre + 3'd1 : 3'd0;
            sync     <= {sync[SYNC_STAGES-2:0], clk_in};
            ext_prev <= sync[SYNC_STAGES-1];
        end
    end

    // NOTE: hit gets a default first so no path through this block infers a latch.
    always_comb begin
        hit = 1'b0;
        case (sel)
            CKS_DIV2: hit = pre[0];
            CKS_DIV4: hit = &pre[1:0];
            CKS_DIV8: hit = &pre;
            CKS_EXT:  hit = sync[SYNC_STAGES-1] & ~ext_prev;
            default:  hit = 1'b0;
        endcase
    end

    assign tick = run & hit;

endmodule

// File: rtl/timer_counter_core.sv
// Up/down timer counter with free-run, auto-reload and one-shot modes and
// sticky overflow / underflow / compare flags.
module timer_counter_core
    import timer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [1:0]       cks,
    input  logic             clk_in,
    input  logic             ovf_clr,
    input  logic             udf_clr,
    input  logic             cmp_clr,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_last,
    output logic             tick,
    output logic             ovf,
    output logic             udf,
    output logic             cmp_match,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             tick_raw;
    logic             step;
    logic             one_shot;
    logic             terminal;
    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] step_val;
    mode_e            mode_eff;
    state_e           state;
    state_e           state_nxt;

    timer_tick_gen #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_gen (
        .pclk     (pclk),
        .preset_n (preset_n),
        .en       (en),
        .load     (load),
        .cks      (cks),
        .clk_in   (clk_in),
        .tick     (tick_raw)
    );

    assign mode_eff = decode_mode(mode);
    assign one_shot = (mode_eff == MODE_ONESHOT);
    assign at_top   = (cnt == '1);
    assign at_zero  = (cnt == '0);
    assign terminal = dir ? at_zero : at_top;

    // A finished one-shot ignores ticks until it is re-armed through IDLE.
    assign step = tick_raw & ~(one_shot & (state == ST_DONE));
    assign tick = step;
    assign busy = (state == ST_RUN);

    always_comb begin
        step_val = dir ? cnt - ONE : cnt + ONE;
        if (terminal) begin
            case (mode_eff)
                MODE_RELOAD:  step_val = load_val;
                MODE_ONESHOT: step_val = cnt;
                default:      ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (!one_shot || !en || load) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: state_nxt = (step && terminal) ? ST_DONE : ST_RUN;
                ST_DONE:         state_nxt = ST_DONE;
                default:         state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset_n) begin
        if (preset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cnt_last  <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            cmp_match <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_last <= cnt;
            if (load) begin
                cnt <= load_val;
            end else if (step) begin
                cnt <= step_val;
            end
            // Set beats clear when both land in the same cycle.
            ovf       <= (step & ~dir & at_top) | (ovf & ~ovf_clr);
            udf       <= (step & dir & at_zero) | (udf & ~udf_clr);
            cmp_match <= (step & ~load & (step_val == cmp_val)) | (cmp_match & ~cmp_clr);
        end
    end

endmodule

// File: tb/tb_timer_counter_core.sv
// Scoreboard bench for timer_counter_core: expected steps are queued as
// stimulus is set up and popped as the DUT reports each tick.
module tb_timer_counter_core;

    logic       pclk = 1'b0;
    logic       preset_n;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] cmp_val;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic [1:0] cks;
    logic       clk_in;
    logic       ovf_clr;
    logic       udf_clr;
    logic       cmp_clr;
    logic [7:0] cnt;
    logic [7:0] cnt_last;
    logic       tick;
    logic       ovf;
    logic       udf;
    logic       cmp_match;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       ovf;
        logic       udf;
        logic       cmp;
        logic       busy;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    logic       mon_en = 1'b0;
    logic       have_prev = 1'b0;
    logic [7:0] prev_cnt;

    timer_counter_core #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .load      (load),
        .load_val  (load_val),
        .cmp_val   (cmp_val),
        .en        (en),
        .dir       (dir),
        .mode      (mode),
        .cks       (cks),
        .clk_in    (clk_in),
        .ovf_clr   (ovf_clr),
        .udf_clr   (udf_clr),
        .cmp_clr   (cmp_clr),
        .cnt       (cnt),
        .cnt_last  (cnt_last),
        .tick      (tick),
        .ovf       (ovf),
        .udf       (udf),
        .cmp_match (cmp_match),
        .busy      (busy)
    );

    always #5 pclk = ~pclk;

    // cnt_last must equal the cnt seen one pclk earlier.
    always @(negedge pclk) begin
        if (mon_en) begin
            if (have_prev) begin
                vectors++;
                if (cnt_last !== prev_cnt) begin
                    miscompares++;
                    $display("FAIL cnt_last_trail: got %h, want %h", cnt_last, prev_cnt);
                end
            end
            prev_cnt  = cnt;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
    end

    function automatic exp_t mk(input logic [7:0] c, input logic o, input logic u,
                                input logic m, input logic b, input int cy);
        exp_t e;
        e.cnt = c; e.ovf = o; e.udf = u; e.cmp = m; e.busy = b; e.cyc = cy;
        return e;
    endfunction

    // Waits (bounded) for a tick; returns the number of posedges up to the update.
    task automatic wait_step(input int max_cyc, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge pclk);
            if (tick === 1'b1) begin
                @(posedge pclk);
                #1;
                cyc = n;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        preset_n = 1'b1;
        load = 1'b0; load_val = 8'h00; cmp_val = 8'hEE;
        en = 1'b0; dir = 1'b0; mode = 2'b00; cks = 2'b00; clk_in = 1'b0;
        ovf_clr = 1'b0; udf_clr = 1'b0; cmp_clr = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset_n = 1'b0;
        @(posedge pclk);
        #1;
    endtask

    task automatic load_value(input logic [7:0] v);
        load = 1'b1; load_val = v;
        @(posedge pclk);
        #1 load = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        bit ok;
        do_reset();
        vectors++;
        if ({cnt, cnt_last, tick, ovf, udf, cmp_match, busy} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_state: cnt=%h last=%h tick=%b ovf=%b udf=%b cmp=%b busy=%b, want all 0",
                     cnt, cnt_last, tick, ovf, udf, cmp_match, busy);
        end
        mode = 2'b10;
        load_value(8'h35);
        en = 1'b1;
        wait_step(6, cyc, ok);
        wait_step(6, cyc, ok);
        vectors++;
        if (!ok || cnt !== 8'h37 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_precount: cnt=%h busy=%b ok=%0d, want cnt=37 busy=1", cnt, busy, ok);
        end
        #2 preset_n = 1'b1;
        #1;
        vectors++;
        if ({cnt, cnt_last, tick, ovf, udf, cmp_match, busy} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_async: cnt=%h last=%h tick=%b busy=%b, want all 0",
                     cnt, cnt_last, tick, busy);
        end
        en = 1'b0;
        @(posedge pclk);
        #1 preset_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        vectors++;
        if (busy !== 1'b0 || cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b cnt=%h, want busy=0 cnt=00", busy, cnt);
        end
    endtask

    task automatic test_free_run();
        int cyc;
        bit ok;
        exp_t e;
        do_reset();
        load_value(8'hFE);
        en = 1'b1;
        exp_q.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        exp_q.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2));
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            wait_step(e.cyc + 4, cyc, ok);
            vectors++;
            if (!ok || cyc != e.cyc || cnt !== e.cnt ||
                {ovf, udf, cmp_match, busy} !== {e.ovf, e.udf, e.cmp, e.busy}) begin
                miscompares++;
                $display("FAIL free_run_step%0d: cnt=%h ovf/udf/cmp/busy=%b cyc=%0d ok=%0d, want cnt=%h %b cyc=%0d",
                         i, cnt, {ovf, udf, cmp_match, busy}, cyc, ok,
                         e.cnt, {e.ovf, e.udf, e.cmp, e.busy}, e.cyc);
            end
        end
        en = 1'b0;
        ovf_clr = 1'b1;
        @(posedge pclk);
        #1 ovf_clr = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_auto_reload();
        int cyc;
        int total;
        bit ok;
        exp_t e;
        do_reset();
        mode = 2'b01; dir = 1'b1; cks = 2'b01;
        load_value(8'h05);
        en = 1'b1;
        total = 0;
        for (int v = 4; v >= 0; v--)
            exp_q.push_back(mk(8'(v), 1'b0, 1'b0, 1'b0, 1'b0, 4));
        exp_q.push_back(mk(8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 4));
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            wait_step(e.cyc + 4, cyc, ok);
            total += cyc;
            vectors++;
            if (!ok || cyc != e.cyc || cnt !== e.cnt ||
                {ovf, udf, cmp_match, busy} !== {e.ovf, e.udf, e.cmp, e.busy}) begin
                miscompares++;
                $display("FAIL reload_step%0d: cnt=%h ovf/udf/cmp/busy=%b cyc=%0d ok=%0d, want cnt=%h %b cyc=%0d",
                         i, cnt, {ovf, udf, cmp_match, busy}, cyc, ok,
                         e.cnt, {e.ovf, e.udf, e.cmp, e.busy}, e.cyc);
            end
        end
        vectors++;
        if (total != 24) begin
            miscompares++;
            $display("FAIL reload_period: %0d pclk, want 24", total);
        end
    endtask

    task automatic test_one_shot_ext();
        int cyc;
        bit ok;
        exp_t e;
        do_reset();
        mode = 2'b10; cks = 2'b11;
        load_value(8'hFC);
        en = 1'b1;
        exp_q.push_back(mk(8'hFD, 1'b0, 1'b0, 1'b0, 1'b1, 3));
        exp_q.push_back(mk(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 3));
        exp_q.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3));
        exp_q.push_back(mk(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            clk_in = 1'b1;
            wait_step(e.cyc + 4, cyc, ok);
            vectors++;
            if (!ok || cyc != e.cyc || cnt !== e.cnt ||
                {ovf, udf, cmp_match, busy} !== {e.ovf, e.udf, e.cmp, e.busy}) begin
                miscompares++;
                $display("FAIL oneshot_rise%0d: cnt=%h ovf/udf/cmp/busy=%b cyc=%0d ok=%0d, want cnt=%h %b cyc=%0d",
                         i, cnt, {ovf, udf, cmp_match, busy}, cyc, ok,
                         e.cnt, {e.ovf, e.udf, e.cmp, e.busy}, e.cyc);
            end
            clk_in = 1'b0;
            repeat (3) @(posedge pclk);
            #1;
        end
        clk_in = 1'b1;
        wait_step(6, cyc, ok);
        vectors++;
        if (ok || cnt !== 8'hFF || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL oneshot_hold: tick_seen=%0d cnt=%h busy=%b, want no tick cnt=FF busy=0",
                     ok, cnt, busy);
        end
        clk_in = 1'b0;
        @(posedge pclk);
        #1 en = 1'b0;
        @(posedge pclk);
        #1 en = 1'b1;
        @(posedge pclk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_rearm: busy=%b, want 1", busy);
        end
        en = 1'b0;
    endtask

    task automatic test_compare();
        int cyc;
        bit ok;
        exp_t e;
        do_reset();
        cmp_val = 8'h10;
        load_value(8'h0E);
        en = 1'b1;
        exp_q.push_back(mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 2));
        exp_q.push_back(mk(8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 2));
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            wait_step(e.cyc + 4, cyc, ok);
            vectors++;
            if (!ok || cyc != e.cyc || cnt !== e.cnt ||
                {ovf, udf, cmp_match, busy} !== {e.ovf, e.udf, e.cmp, e.busy}) begin
                miscompares++;
                $display("FAIL compare_step%0d: cnt=%h ovf/udf/cmp/busy=%b cyc=%0d ok=%0d, want cnt=%h %b cyc=%0d",
                         i, cnt, {ovf, udf, cmp_match, busy}, cyc, ok,
                         e.cnt, {e.ovf, e.udf, e.cmp, e.busy}, e.cyc);
            end
        end
        en = 1'b0;
        cmp_clr = 1'b1;
        @(posedge pclk);
        #1 cmp_clr = 1'b0;
        vectors++;
        if (cmp_match !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_clear: cmp_match=%b, want 0", cmp_match);
        end
        load_value(8'h0F);
        en = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge pclk);
            if (tick === 1'b1) begin
                ok = 1'b1;
                cmp_clr = 1'b1;
                break;
            end
        end
        @(posedge pclk);
        #1 cmp_clr = 1'b0;
        vectors++;
        if (!ok || cnt !== 8'h10 || cmp_match !== 1'b1) begin
            miscompares++;
            $display("FAIL cmp_set_wins: ok=%0d cnt=%h cmp_match=%b, want cnt=10 cmp_match=1",
                     ok, cnt, cmp_match);
        end
        en = 1'b0;
    endtask

    task automatic test_load_vs_tick();
        int cyc;
        bit ok;
        exp_t e;
        do_reset();
        cmp_val = 8'hAB;
        mon_en  = 1'b1;
        load_value(8'h20);
        en = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge pclk);
            if (tick === 1'b1) begin
                ok = 1'b1;
                load = 1'b1;
                load_val = 8'hAA;
                break;
            end
        end
        @(posedge pclk);
        #1;
        vectors++;
        if (!ok || cnt !== 8'hAA || {ovf, udf, cmp_match} !== 3'b000) begin
            miscompares++;
            $display("FAIL load_beats_tick: ok=%0d cnt=%h ovf/udf/cmp=%b, want cnt=AA flags 000",
                     ok, cnt, {ovf, udf, cmp_match});
        end
        @(negedge pclk);
        vectors++;
        if (tick !== 1'b0) begin
            miscompares++;
            $display("FAIL load_no_tick: tick=%b, want 0", tick);
        end
        @(posedge pclk);
        #1 load = 1'b0;
        exp_q.push_back(mk(8'hAB, 1'b0, 1'b0, 1'b1, 1'b0, 2));
        e = exp_q.pop_front();
        wait_step(e.cyc + 4, cyc, ok);
        vectors++;
        if (!ok || cyc != e.cyc || cnt !== e.cnt ||
            {ovf, udf, cmp_match, busy} !== {e.ovf, e.udf, e.cmp, e.busy}) begin
            miscompares++;
            $display("FAIL load_resume: cnt=%h ovf/udf/cmp/busy=%b cyc=%0d ok=%0d, want cnt=%h %b cyc=%0d",
                     cnt, {ovf, udf, cmp_match, busy}, cyc, ok,
                     e.cnt, {e.ovf, e.udf, e.cmp, e.busy}, e.cyc);
        end
        repeat (3) @(posedge pclk);
        #1;
        en = 1'b0;
        mon_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_free_run();
        test_auto_reload();
        test_one_shot_ext();
        test_compare();
        test_load_vs_tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
